mem_bus_ctrl: RTL and testbench

- Parametrised, sequential successor to the Hack memory-map decoder: one request/response port routes accesses to a synchronous data RAM region or to IO_CH memory-mapped I/O channels.
- Adds request/response handshake, registered read data, per-channel acknowledge with timeout, and an error response for unmapped addresses.
- Sits between the CPU data port and the RAM / peripheral registers.

---
 rtl/mem_bus_pkg.sv | 26 ++
 rtl/mem_bus_decode.sv | 36 +++
 rtl/mem_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and default address map for the memory bus controller.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_ACC,
        RAM_CAP,
        IO_WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_NONE
    } region_t;

    localparam int RAM_WORDS_DEF = 8192;
    localparam int IO_BASE_DEF   = 'h2000;

    // Channel index width; at least one bit so a single-channel build still has a select.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address-to-region decoder with I/O channel index.
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAM_WORDS = RAM_WORDS_DEF,
    parameter int IO_BASE   = IO_BASE_DEF,
    parameter int IO_CH     = 16,
    parameter int CH_W      = ch_bits(IO_CH)
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic [CH_W-1:0]   ch
);

    // One extra bit so RAM_WORDS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   RAM_LIM   = (ADDR_W+1)'(RAM_WORDS);
    localparam logic [ADDR_W:0]   IO_LIM    = (ADDR_W+1)'(IO_CH);
    localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

    logic [ADDR_W-1:0] off;

    // Offset from the I/O base wraps at ADDR_W; the lower bound test rejects wrapped values.
    assign off = addr - IO_BASE_A;
    assign ch  = off[CH_W-1:0];

    // RAM takes priority, then the I/O window, everything else is unmapped.
    always_comb begin
        region = REG_NONE;
        if ({1'b0, addr} < RAM_LIM)
            region = REG_RAM;
        else if ((addr >= IO_BASE_A) && ({1'b0, off} < IO_LIM))
            region = REG_IO;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-port request/response controller routing to synchronous RAM or I/O channels.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RAM_WORDS = RAM_WORDS_DEF,
    parameter int IO_BASE   = IO_BASE_DEF,
    parameter int IO_CH     = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic                     req_we,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_we,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic [IO_CH-1:0]         io_sel,
    output logic                     io_we,
    output logic [DATA_W-1:0]        io_wdata,
    input  logic [IO_CH*DATA_W-1:0]  io_rdata,
    input  logic [IO_CH-1:0]         io_ack
);

    localparam int CH_W = ch_bits(IO_CH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [CH_W-1:0]   ch;
    } req_t;

    state_t                         state, state_n;
    req_t                           req_q;
    logic [7:0]                     cnt_q, cnt_n;
    logic [DATA_W-1:0]              rdata_q, rdata_n;
    logic                           err_q, err_n;
    logic                           rsp_load, accept;
    region_t                        dec_region;
    logic [CH_W-1:0]                dec_ch;
    logic [IO_CH-1:0][DATA_W-1:0]   io_rd;

    assign io_rd = io_rdata;

    mem_bus_decode #(
        .ADDR_W    (ADDR_W),
        .RAM_WORDS (RAM_WORDS),
        .IO_BASE   (IO_BASE),
        .IO_CH     (IO_CH),
        .CH_W      (CH_W)
    ) u_decode (
        .addr   (req_addr),
        .region (dec_region),
        .ch     (dec_ch)
    );

    // Address and write data come straight from the latched request.
    assign ram_addr  = req_q.addr;
    assign ram_wdata = req_q.wdata;
    assign io_wdata  = req_q.wdata;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // State register; reset aborts any outstanding transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Request latch, wait counter and response registers (held until the next response).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) req_q <= '{addr: req_addr, we: req_we, wdata: req_wdata, ch: dec_ch};
            cnt_q <= cnt_n;
            if (rsp_load) begin
                rdata_q <= rdata_n;
                err_q   <= err_n;
            end
        end
    end

    // Next-state, response capture and strobes, all decoded from the current state.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt_q;
        rsp_load  = 1'b0;
        rdata_n   = '0;
        err_n     = 1'b0;
        accept    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_we    = 1'b0;
        io_sel    = '0;
        io_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    case (dec_region)
                        REG_RAM: state_n = RAM_ACC;
                        REG_IO:  state_n = IO_WAIT;
                        default: begin
                            state_n  = RESP;
                            rsp_load = 1'b1;
                            err_n    = 1'b1;
                        end
                    endcase
                end
            end
            RAM_ACC: begin
                ram_we  = req_q.we;
                state_n = RAM_CAP;
            end
            RAM_CAP: begin
                state_n  = RESP;
                rsp_load = 1'b1;
                if (!req_q.we) rdata_n = ram_rdata;
            end
            IO_WAIT: begin
                io_sel = IO_CH'(1) << req_q.ch;
                io_we  = req_q.we;
                // The selected ack is checked first so an ack on the last allowed cycle wins.
                if (io_ack[req_q.ch]) begin
                    state_n  = RESP;
                    rsp_load = 1'b1;
                    cnt_n    = '0;
                    if (!req_q.we) rdata_n = io_rd[req_q.ch];
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_n  = RESP;
                    rsp_load = 1'b1;
                    err_n    = 1'b1;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl with a behavioural RAM and a transaction-level model.
module tb_mem_bus_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we;
    logic [15:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_err;
    logic [15:0]   rsp_rdata;
    logic [15:0]   ram_addr, ram_wdata, ram_rdata;
    logic          ram_we;
    logic [15:0]   io_sel, io_ack, io_wdata;
    logic          io_we;
    logic [255:0]  io_rdata;

    int checks   = 0;
    int failures = 0;

    bit   [15:0] mem [0:8191];
    logic [15:0] ref_wr [int];

    mem_bus_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_sel(io_sel), .io_we(io_we), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    // Power-up RAM content; mem stores the difference so no preload is needed.
    function automatic logic [15:0] init_val(input logic [12:0] a);
        return 16'({3'b000, a} * 16'h9E37 + 16'h1234);
    endfunction

    // Synchronous RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[12:0]] <= ram_wdata ^ init_val(ram_addr[12:0]);
        ram_rdata <= mem[ram_addr[12:0]] ^ init_val(ram_addr[12:0]);
    end

    // Transaction-level expectation from the address map and handshake rules.
    task automatic model(input logic [15:0] a, input logic we, input logic [15:0] wd, input int ack_after,
                         output int lat, output logic [15:0] rd, output logic err,
                         output int sel_cyc, output logic [15:0] sel, output int ramwe);
        lat = 1; rd = '0; err = 1'b1; sel_cyc = 0; sel = '0; ramwe = 0;
        if (a < 16'd8192) begin
            lat = 3; err = 1'b0; ramwe = we ? 1 : 0;
            if (we) ref_wr[int'(a)] = wd;
            else    rd = ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : init_val(a[12:0]);
        end else if (a >= 16'h2000 && a < 16'h2010) begin
            sel = 16'(1) << (a - 16'h2000);
            if (ack_after >= 0 && ack_after < 15) begin
                sel_cyc = ack_after + 1; lat = ack_after + 2; err = 1'b0;
                rd = we ? 16'h0 : 16'hBF00 + (a - 16'h2000);
            end else begin
                sel_cyc = 15; lat = 16;
            end
        end
    endtask

    // Issue one request and observe it; ack on the (ack_after+1)-th select cycle, stray bits otherwise.
    task automatic xact(input logic [15:0] a, input logic we, input logic [15:0] wd, input int ack_after,
                        input logic [15:0] stray,
                        output int lat, output logic [15:0] rd, output logic err, output int sel_cyc,
                        output int iowe_cyc, output int ramwe_cyc, output logic [15:0] sel_seen,
                        output int rdy_busy, output logic after_ok);
        lat = -1; rd = '0; err = 1'b0; sel_cyc = 0; iowe_cyc = 0; ramwe_cyc = 0;
        sel_seen = '0; rdy_busy = 0; after_ok = 1'b0;
        for (int w = 0; w < 50 && !req_ready; w++) begin @(posedge clk); #1; end
        req_addr = a; req_we = we; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (rsp_valid) begin lat = n; rd = rsp_rdata; err = rsp_err; break; end
            if (req_ready) rdy_busy++;
            if (ram_we) ramwe_cyc++;
            if (io_we) iowe_cyc++;
            if (io_sel != 16'h0) begin
                sel_seen = io_sel;
                io_ack = (ack_after == sel_cyc) ? io_sel : stray;
                sel_cyc++;
            end
            @(posedge clk); #1;
            io_ack = '0;
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            after_ok = !rsp_valid && io_sel == 16'h0 && req_ready && rsp_rdata === rd && rsp_err === err;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({req_ready, rsp_valid, ram_we, io_we, rsp_err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got rdy/vld/ramwe/iowe/err=%b expected 10000",
                     {req_ready, rsp_valid, ram_we, io_we, rsp_err});
        end
        checks++;
        if ({io_sel, rsp_rdata, ram_addr, ram_wdata, io_wdata} !== 80'h0) begin
            failures++;
            $display("FAIL reset_data got sel=%h rdata=%h raddr=%h rwd=%h iowd=%h expected all 0",
                     io_sel, rsp_rdata, ram_addr, ram_wdata, io_wdata);
        end
    endtask

    task automatic test_ram_wr_rd;
        int lat, elat, sc, esc, iw, rw, erw, rb; logic [15:0] rd, erd, sel, esel; logic err, eerr, ok;
        model(16'h1FFC, 1'b1, 16'hBEEF, 0, elat, erd, eerr, esc, esel, erw);
        xact(16'h1FFC, 1'b1, 16'hBEEF, 0, 16'h0, lat, rd, err, sc, iw, rw, sel, rb, ok);
        checks++;
        if (lat !== elat || rd !== erd || err !== eerr || rw !== 1 || !ok) begin
            failures++;
            $display("FAIL ram_write got lat=%0d rd=%h err=%b we_cyc=%0d post=%b expected lat=%0d rd=%h err=%b we_cyc=1 post=1",
                     lat, rd, err, rw, ok, elat, erd, eerr);
        end
        model(16'h1FFC, 1'b0, 16'h0, 0, elat, erd, eerr, esc, esel, erw);
        xact(16'h1FFC, 1'b0, 16'h0, 0, 16'h0, lat, rd, err, sc, iw, rw, sel, rb, ok);
        checks++;
        if (lat !== 3 || rd !== 16'hBEEF || err !== 1'b0 || rw !== 0 || !ok) begin
            failures++;
            $display("FAIL ram_read got lat=%0d rd=%h err=%b we_cyc=%0d post=%b expected lat=3 rd=beef err=0 we_cyc=0 post=1",
                     lat, rd, err, rw, ok);
        end
    endtask

    task automatic test_io_write;
        int lat, sc, iw, rw, rb; logic [15:0] rd, sel; logic err, ok;
        xact(16'h2003, 1'b1, 16'hBF03, 2, 16'h0, lat, rd, err, sc, iw, rw, sel, rb, ok);
        checks++;
        if (sel !== 16'h0008 || sc !== 3 || iw !== 3 || lat !== 4 || err !== 1'b0 || rd !== 16'h0 || !ok) begin
            failures++;
            $display("FAIL io_write got sel=%h sel_cyc=%0d iowe=%0d lat=%0d err=%b rd=%h post=%b expected 0008 3 3 4 0 0000 1",
                     sel, sc, iw, lat, err, rd, ok);
        end
    endtask

    task automatic test_sweep;
        int lat, elat, sc, esc, iw, rw, erw, rb; logic [15:0] rd, erd, sel, esel; logic err, eerr, ok;
        for (int a = 'h1FFC; a <= 'h2010; a++) begin
            model(16'(a), 1'b0, 16'h0, 0, elat, erd, eerr, esc, esel, erw);
            xact(16'(a), 1'b0, 16'h0, 0, 16'h0, lat, rd, err, sc, iw, rw, sel, rb, ok);
            checks++;
            if (lat !== elat || rd !== erd || err !== eerr || sel !== esel || sc !== esc || !ok) begin
                failures++;
                $display("FAIL sweep_%h got lat=%0d rd=%h err=%b sel=%h post=%b expected lat=%0d rd=%h err=%b sel=%h",
                         16'(a), lat, rd, err, sel, ok, elat, erd, eerr, esel);
            end
        end
    endtask

    task automatic test_timeout;
        int lat, sc, iw, rw, rb; logic [15:0] rd, sel; logic err, ok;
        xact(16'h2005, 1'b0, 16'h0, -1, 16'h0010, lat, rd, err, sc, iw, rw, sel, rb, ok);
        checks++;
        if (sel !== 16'h0020 || sc !== 15 || lat !== 16 || err !== 1'b1 || rd !== 16'h0 || !ok) begin
            failures++;
            $display("FAIL timeout got sel=%h sel_cyc=%0d lat=%0d err=%b rd=%h post=%b expected 0020 15 16 1 0000 1",
                     sel, sc, lat, err, rd, ok);
        end
    endtask

    task automatic test_ack_on_timeout;
        int lat, sc, iw, rw, rb; logic [15:0] rd, sel; logic err, ok;
        xact(16'h2005, 1'b0, 16'h0, 14, 16'h0, lat, rd, err, sc, iw, rw, sel, rb, ok);
        checks++;
        if (sc !== 15 || lat !== 16 || err !== 1'b0 || rd !== 16'hBF05 || !ok) begin
            failures++;
            $display("FAIL ack_on_timeout got sel_cyc=%0d lat=%0d err=%b rd=%h post=%b expected 15 16 0 bf05 1",
                     sc, lat, err, rd, ok);
        end
    endtask

    task automatic test_random;
        int lat, elat, sc, esc, iw, rw, erw, rb, ack_after, kind;
        logic [15:0] rd, erd, sel, esel, a, wd, stray; logic err, eerr, ok, we;
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 3));
            stray = '0;
            if (kind < 2)       a = 16'h1FF0 + 16'($urandom_range(0, 15));
            else if (kind == 2) a = 16'h2000 + 16'($urandom_range(0, 15));
            else                a = 16'($urandom_range(16'h2010, 16'hFFFF));
            if (kind == 2) stray = 16'($urandom) & ~(16'(1) << (a - 16'h2000));
            we = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            ack_after = int'($urandom_range(0, 17)) - 1;
            model(a, we, wd, ack_after, elat, erd, eerr, esc, esel, erw);
            xact(a, we, wd, ack_after, stray, lat, rd, err, sc, iw, rw, sel, rb, ok);
            checks++;
            if (lat !== elat || rd !== erd || err !== eerr || sel !== esel || sc !== esc ||
                rw !== erw || iw !== (we ? esc : 0) || rb !== 0 || !ok) begin
                failures++;
                $display("FAIL rand_%0d a=%h we=%b got lat=%0d rd=%h err=%b sel=%h sc=%0d rw=%0d iw=%0d busy=%0d post=%b expected lat=%0d rd=%h err=%b sel=%h sc=%0d rw=%0d",
                         t, a, we, lat, rd, err, sel, sc, rw, iw, rb, ok, elat, erd, eerr, esel, esc, erw);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat, elat, sc, esc, iw, rw, erw, rb, seen; logic [15:0] rd, erd, sel, esel; logic err, eerr, ok;
        req_addr = 16'h2007; req_we = 1'b1; req_wdata = 16'h1234; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (io_sel !== 16'h0080) begin
            failures++;
            $display("FAIL mid_pre_sel got %h expected 0080", io_sel);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (io_sel !== 16'h0 || ram_we !== 1'b0 || io_we !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_clear got sel=%h ramwe=%b iowe=%b vld=%b expected 0 0 0 0",
                     io_sel, ram_we, io_we, rsp_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || !req_ready || io_sel != 16'h0) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_after got bad_cycles=%0d rdata=%h err=%b expected 0 0000 0", seen, rsp_rdata, rsp_err);
        end
        model(16'h1FFC, 1'b0, 16'h0, 0, elat, erd, eerr, esc, esel, erw);
        xact(16'h1FFC, 1'b0, 16'h0, 0, 16'h0, lat, rd, err, sc, iw, rw, sel, rb, ok);
        checks++;
        if (lat !== elat || rd !== erd || err !== eerr || !ok) begin
            failures++;
            $display("FAIL mid_next_read got lat=%0d rd=%h err=%b post=%b expected lat=%0d rd=%h err=%b",
                     lat, rd, err, ok, elat, erd, eerr);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; io_ack = '0;
        for (int i = 0; i < 16; i++) io_rdata[i*16 +: 16] = 16'hBF00 + 16'(i);
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b0;
        @(posedge clk); #1;
        test_ram_wr_rd;
        test_io_write;
        test_sweep;
        test_timeout;
        test_ack_on_timeout;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
